// File: rtl/duft_pkg.sv
// Shared constants for the DUFT host-controlled test wrapper: register map,
// opcodes, controller/handshake state encodings and the opcode decoder.
package duft_pkg;

  localparam int DATA_W    = 32;
  localparam int DUT_ITERS = 8;

  localparam logic [DATA_W-1:0] ADDR_OPCODE   = 32'h0000_0000;
  localparam logic [DATA_W-1:0] ADDR_STATUS   = 32'h0000_0001;
  localparam logic [DATA_W-1:0] ADDR_CONFIG   = 32'h0000_0002;
  localparam logic [DATA_W-1:0] ADDR_DUT_IN   = 32'h0000_0010;
  localparam logic [DATA_W-1:0] ADDR_DUT_OUT  = 32'h0000_0018;
  localparam logic [DATA_W-1:0] ADDR_DFT_OUT0 = 32'h0000_0020;
  localparam logic [DATA_W-1:0] ADDR_TEST_IN  = 32'hFF00_0000;
  localparam logic [DATA_W-1:0] ADDR_TEST_OUT = 32'hFF00_0001;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_INPUT = 3'd1,
    OP_RUN   = 3'd2,
    OP_ENDR  = 3'd3,
    OP_TEST  = 3'd4,
    OP_NEXT  = 3'd5,
    OP_ENDT  = 3'd6
  } opcode_t;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_INPUT_FLATTEN = 4'd1,
    ST_INPUT_DUT     = 4'd2,
    ST_INPUT_RDY     = 4'd3,
    ST_OUTPUT_WAIT   = 4'd4,
    ST_OUTPUT_VAL    = 4'd5,
    ST_OUTPUT_PACK   = 4'd6,
    ST_SCAN_PREP     = 4'd7,
    ST_SCAN          = 4'd8,
    ST_SCAN_RD       = 4'd9,
    ST_TICK          = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_BUSY = 2'd1,
    HS_DONE = 2'd2
  } hs_t;

  // Out-of-range opcode values collapse to NONE so they are never acted on.
  function automatic opcode_t decode_op(input logic [DATA_W-1:0] value);
    if (value <= 32'd6) return opcode_t'(value[2:0]);
    else                return OP_NONE;
  endfunction

endpackage

// File: rtl/duft_dut.sv
// Embedded iterative DUT: loads an operand, adds one per enabled clock and
// commits after DUT_ITERS enables; exposes its accumulator as a scan port.
module duft_dut
  import duft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              val_op,
  input  logic [DATA_W-1:0] din,
  input  logic              clk_en,
  input  logic              commit_clr,
  input  logic              scan_req,
  output logic              op_ack,
  output logic              op_commit,
  output logic              scan_ack,
  output logic [DATA_W-1:0] scan_data,
  output logic [DATA_W-1:0] dout
);

  localparam logic [3:0] LAST_ITER = 4'(DUT_ITERS - 1);

  logic [DATA_W-1:0] acc;
  logic [3:0]        cnt;
  logic              commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      commit <= 1'b0;
    end else if (val_op) begin
      acc    <= din;
      cnt    <= '0;
      commit <= 1'b0;
    end else if (commit_clr) begin
      commit <= 1'b0;
    end else if (clk_en && !commit) begin
      // Enables after completion are ignored so the result stays at din+8.
      acc <= acc + 32'd1;
      cnt <= cnt + 4'd1;
      if (cnt == LAST_ITER) commit <= 1'b1;
    end
  end

  assign op_ack    = val_op;
  assign op_commit = commit;
  assign scan_ack  = scan_req;
  assign scan_data = acc;
  assign dout      = acc;

endmodule

// File: rtl/duft_ap_ctrl_hs.sv
// DUFT controller behind an ap_ctrl_hs host handshake: register file,
// opcode-driven run/scan FSM and the embedded duft_dut.
// Optional TEST_IN/TEST_OUT loopback register enabled by DUFT_TEST_REG_EN.
module duft_ap_ctrl_hs (
  input  logic        clk,
  input  logic        ap_rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        rd_wr,
  input  logic        ap_start,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic        ap_done,
  output logic [31:0] ap_return
);
  import duft_pkg::*;

  hs_t               hs;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              host_we;

  state_t            state;
  state_t            state_nx;
  opcode_t           opcode;

  logic [DATA_W-1:0] config_q;
  logic [DATA_W-1:0] dut_in;
  logic [DATA_W-1:0] dut_out;
  logic [DATA_W-1:0] dft_out0;
  logic [DATA_W-1:0] scan_data;
  logic [DATA_W-1:0] dut_dout;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_data;

  logic dut_val_op, dut_op_ack, dut_op_commit, dut_commit_ack;
  logic dft_val_op, dft_op_ack, dft_op_commit, dft_commit_ack;
  logic clk_en;
  logic commit_clr;

`ifdef DUFT_TEST_REG_EN
  logic [DATA_W-1:0] test_reg;
`endif

  assign ap_idle  = (hs == HS_IDLE);
  assign ap_done  = (hs == HS_DONE);
  assign ap_ready = ap_done;
  assign host_we  = (hs == HS_BUSY) && !rd_q;

  // Host handshake: latch on start, apply on the next edge, done for one cycle.
  always_ff @(posedge clk or negedge ap_rst) begin
    if (!ap_rst) begin
      hs        <= HS_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      ap_return <= '0;
    end else begin
      case (hs)
        HS_IDLE: if (ap_start) begin
          addr_q  <= addr;
          wdata_q <= wr_data;
          rd_q    <= rd_wr;
          hs      <= HS_BUSY;
        end
        HS_BUSY: begin
          if (rd_q) ap_return <= rd_data;
          hs <= HS_DONE;
        end
        default: hs <= HS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge ap_rst) begin
    if (!ap_rst) begin
      config_q <= '0;
      dut_in   <= '0;
      opcode   <= OP_NONE;
      dut_out  <= '0;
      dft_out0 <= '0;
      dft_op_commit <= 1'b0;
    end else begin
      if (host_we && addr_q == ADDR_CONFIG) config_q <= wdata_q;
      if (host_we && addr_q == ADDR_DUT_IN) dut_in   <= wdata_q;
      // A host write wins over consumption of the previous opcode.
      if (host_we && addr_q == ADDR_OPCODE) opcode <= decode_op(wdata_q);
      else if (opcode != OP_NONE)           opcode <= OP_NONE;
      if (state == ST_OUTPUT_PACK) dut_out  <= dut_dout;
      if (dft_op_ack)              dft_out0 <= scan_data;
      if (commit_clr)              dft_op_commit <= 1'b0;
      else if (dft_op_ack)         dft_op_commit <= 1'b1;
    end
  end

`ifdef DUFT_TEST_REG_EN
  always_ff @(posedge clk or negedge ap_rst) begin
    if (!ap_rst)                            test_reg <= '0;
    else if (host_we && addr_q == ADDR_TEST_IN) test_reg <= wdata_q;
  end
`endif

  always_ff @(posedge clk or negedge ap_rst) begin
    if (!ap_rst) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:          if (opcode == OP_INPUT) state_nx = ST_INPUT_FLATTEN;
      ST_INPUT_FLATTEN: state_nx = ST_INPUT_DUT;
      ST_INPUT_DUT:     if (dut_op_ack) state_nx = ST_INPUT_RDY;
      ST_INPUT_RDY: begin
        if (opcode == OP_RUN)       state_nx = ST_OUTPUT_WAIT;
        else if (opcode == OP_TEST) state_nx = ST_SCAN_PREP;
      end
      ST_OUTPUT_WAIT:   if (dut_op_commit) state_nx = ST_OUTPUT_VAL;
      ST_OUTPUT_VAL:    if (opcode == OP_ENDR) state_nx = ST_OUTPUT_PACK;
      ST_OUTPUT_PACK:   state_nx = ST_IDLE;
      ST_SCAN_PREP:     state_nx = ST_SCAN;
      ST_SCAN:          state_nx = ST_SCAN_RD;
      ST_SCAN_RD: begin
        if (opcode == OP_NEXT)      state_nx = ST_TICK;
        else if (opcode == OP_ENDT) state_nx = ST_IDLE;
      end
      ST_TICK:          state_nx = ST_SCAN;
      default:          state_nx = ST_IDLE;
    endcase
  end

  assign dut_val_op     = (state == ST_INPUT_DUT);
  assign dut_commit_ack = (state == ST_OUTPUT_PACK);
  assign dft_val_op     = (state == ST_SCAN);
  assign dft_commit_ack = (state == ST_TICK);
  assign clk_en         = (state == ST_OUTPUT_WAIT) || (state == ST_TICK);
  assign commit_clr     = (state != ST_IDLE) && (state_nx == ST_IDLE);

  duft_dut u_dut (
    .clk       (clk),
    .rst_n     (ap_rst),
    .val_op    (dut_val_op),
    .din       (dut_in),
    .clk_en    (clk_en),
    .commit_clr(commit_clr),
    .scan_req  (dft_val_op),
    .op_ack    (dut_op_ack),
    .op_commit (dut_op_commit),
    .scan_ack  (dft_op_ack),
    .scan_data (scan_data),
    .dout      (dut_dout)
  );

  assign status = {20'd0,
                   dft_val_op, dft_op_ack, dft_op_commit, dft_commit_ack,
                   dut_val_op, dut_op_ack, dut_op_commit, dut_commit_ack,
                   state};

  always_comb begin
    rd_data = '0;
    case (addr_q)
      ADDR_STATUS:   rd_data = status;
      ADDR_CONFIG:   rd_data = config_q;
      ADDR_DUT_IN:   rd_data = dut_in;
      ADDR_DUT_OUT:  rd_data = dut_out;
      ADDR_DFT_OUT0: rd_data = dft_out0;
`ifdef DUFT_TEST_REG_EN
      ADDR_TEST_OUT: rd_data = test_reg;
`endif
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_duft_ap_ctrl_hs.sv
// Self-checking bench for duft_ap_ctrl_hs: host transactions through the
// ap_ctrl_hs handshake with expected read data queued in a scoreboard.
module tb_duft_ap_ctrl_hs;

  localparam logic [31:0] A_OPCODE   = 32'h0000_0000;
  localparam logic [31:0] A_STATUS   = 32'h0000_0001;
  localparam logic [31:0] A_CONFIG   = 32'h0000_0002;
  localparam logic [31:0] A_DUT_IN   = 32'h0000_0010;
  localparam logic [31:0] A_DUT_OUT  = 32'h0000_0018;
  localparam logic [31:0] A_DFT_OUT0 = 32'h0000_0020;
  localparam logic [31:0] A_TEST_IN  = 32'hFF00_0000;
  localparam logic [31:0] A_TEST_OUT = 32'hFF00_0001;
  localparam logic [31:0] A_UNMAP    = 32'h0000_0003;
  localparam logic [31:0] A_ALLONES  = 32'hFFFF_FFFF;

  localparam logic [31:0] OPC_INPUT = 32'd1;
  localparam logic [31:0] OPC_RUN   = 32'd2;
  localparam logic [31:0] OPC_ENDR  = 32'd3;
  localparam logic [31:0] OPC_TEST  = 32'd4;
  localparam logic [31:0] OPC_NEXT  = 32'd5;
  localparam logic [31:0] OPC_ENDT  = 32'd6;

`ifdef DUFT_TEST_REG_EN
  localparam logic [31:0] TEST_EXP = 32'h0000_7216;
`else
  localparam logic [31:0] TEST_EXP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_wr = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_ready, ap_done;
  logic [31:0] ap_return;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  duft_ap_ctrl_hs dut (
    .clk      (clk),
    .ap_rst   (ap_rst),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_wr    (rd_wr),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .ap_done  (ap_done),
    .ap_return(ap_return)
  );

  task automatic xact(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata);
    int n;
    rdata = '0;
    @(negedge clk);
    n = 0;
    while (ap_idle !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ap_idle !== 1'b1) begin
      checks++; errors++;
      $display("FAIL idle_wait: ap_idle=%b required 1", ap_idle);
    end
    rd_wr = rd; addr = a; wr_data = wd; ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ap_done !== 1'b1 && n < 10);
    if (ap_done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_wait: ap_done=%b required 1 (addr %h)", ap_done, a);
    end
    rdata = ap_return;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused;
    xact(1'b0, a, d, unused);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    xact(1'b1, a, 32'd0, d);
  endtask

  task automatic wait_state(input logic [3:0] s, output logic [31:0] st);
    for (int i = 0; i < 30; i++) begin
      rd(A_STATUS, st);
      if (st[3:0] == s) break;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r, e;
    ap_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ap_idle !== 1'b1)   begin errors++; $display("FAIL rst_idle: got %b want 1", ap_idle); end
    checks++; if (ap_done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b want 0", ap_done); end
    checks++; if (ap_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %b want 0", ap_ready); end
    checks++; if (ap_return !== 32'd0) begin errors++; $display("FAIL rst_return: got %h want 0", ap_return); end
    ap_rst = 1'b1;
    sb_q.push_back(32'd0);
    rd(A_STATUS, r);
    e = sb_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL rst_status: got %h want %h", r, e); end
  endtask

  task automatic test_handshake();
    logic [31:0] r, e;
    logic [31:0] wa [11];
    logic [31:0] wd [11];
    logic [31:0] ra [11];
    logic [31:0] ex [11];
    @(negedge clk);
    rd_wr = 1'b0; addr = A_CONFIG; wr_data = 32'hA5A5_5A5A; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    checks++; if (ap_idle !== 1'b0 || ap_done !== 1'b0)
      begin errors++; $display("FAIL hs_busy: idle=%b done=%b want 0 0", ap_idle, ap_done); end
    @(negedge clk);
    checks++; if (ap_done !== 1'b1 || ap_ready !== 1'b1 || ap_idle !== 1'b0)
      begin errors++; $display("FAIL hs_done: done=%b ready=%b idle=%b want 1 1 0", ap_done, ap_ready, ap_idle); end
    @(negedge clk);
    checks++; if (ap_done !== 1'b0 || ap_ready !== 1'b0 || ap_idle !== 1'b1)
      begin errors++; $display("FAIL hs_back: done=%b ready=%b idle=%b want 0 0 1", ap_done, ap_ready, ap_idle); end

    wa = '{A_CONFIG, A_DUT_IN, A_OPCODE, A_STATUS, A_DUT_OUT, A_DFT_OUT0, A_UNMAP, A_ALLONES, A_TEST_IN, A_UNMAP, A_TEST_OUT};
    wd = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0, 32'hFFFF, 32'h55, 32'h66, 32'h77, 32'h88, 32'h7216, 32'h99, 32'h1234};
    ra = '{A_CONFIG, A_DUT_IN, A_OPCODE, A_STATUS, A_DUT_OUT, A_DFT_OUT0, A_UNMAP, A_ALLONES, A_TEST_OUT, A_CONFIG, A_TEST_IN};
    ex = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, TEST_EXP, 32'h1234_5678, 32'h0};
    for (int i = 0; i < 11; i++) begin
      wr(wa[i], wd[i]);
      sb_q.push_back(ex[i]);
      rd(ra[i], r);
      e = sb_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL regmap[%0d] addr %h: got %h want %h", i, ra[i], r, e); end
    end
  endtask

  task automatic run_one(input logic [31:0] din);
    logic [31:0] st, r, e;
    wr(A_DUT_IN, din);
    wr(A_OPCODE, OPC_INPUT);
    wait_state(4'd3, st);
    checks++; if (st !== 32'h3) begin errors++; $display("FAIL run_input_rdy %h: status %h want 3", din, st); end
    wr(A_OPCODE, OPC_RUN);
    wait_state(4'd5, st);
    checks++; if (st !== 32'h25) begin errors++; $display("FAIL run_output_val %h: status %h want 25", din, st); end
    wr(A_OPCODE, OPC_ENDR);
    wait_state(4'd0, st);
    checks++; if (st !== 32'h0) begin errors++; $display("FAIL run_idle %h: status %h want 0", din, st); end
    sb_q.push_back(din + 32'd8);
    rd(A_DUT_OUT, r);
    e = sb_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL run_dut_out in=%h: got %h want %h", din, r, e); end
  endtask

  task automatic test_run_flow();
    run_one(32'h0000_7216);
    run_one(32'h0000_0722);
  endtask

  task automatic test_random();
    logic [31:0] v;
    run_one(32'hFFFF_FFF8);
    for (int i = 0; i < 100; i++) begin
      v = $urandom;
      run_one(v);
    end
  endtask

  task automatic test_scan();
    logic [31:0] st, r, e, exp_st;
    wr(A_DUT_IN, 32'h0000_7216);
    wr(A_OPCODE, OPC_INPUT);
    wait_state(4'd3, st);
    wr(A_OPCODE, OPC_TEST);
    wait_state(4'd9, st);
    for (int k = 0; k <= 8; k++) begin
      exp_st = (k == 8) ? 32'h229 : 32'h209;
      rd(A_STATUS, st);
      checks++; if (st !== exp_st) begin errors++; $display("FAIL scan_status[%0d]: got %h want %h", k, st, exp_st); end
      sb_q.push_back(32'h0000_7216 + 32'(k));
      rd(A_DFT_OUT0, r);
      e = sb_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL scan_snapshot[%0d]: got %h want %h", k, r, e); end
      if (k < 8) begin
        wr(A_OPCODE, OPC_NEXT);
        wait_state(4'd9, st);
      end
    end
    wr(A_OPCODE, OPC_RUN);
    rd(A_STATUS, st);
    checks++; if (st !== 32'h229) begin errors++; $display("FAIL scan_bad_op: status %h want 229", st); end
    wr(A_OPCODE, OPC_ENDT);
    wait_state(4'd0, st);
    checks++; if (st !== 32'h0) begin errors++; $display("FAIL scan_endt: status %h want 0", st); end
  endtask

  task automatic test_invalid();
    logic [31:0] r;
    wr(A_OPCODE, OPC_RUN);
    rd(A_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL inv_run_idle: status %h want 0", r); end
    rd(A_OPCODE, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL inv_opcode_rd: got %h want 0", r); end
    wr(A_OPCODE, 32'd7);
    rd(A_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL inv_op7: status %h want 0", r); end
    rd(A_ALLONES, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL inv_allones: got %h want 0", r); end
    checks++; if (ap_done !== 1'b1 || ap_ready !== 1'b1)
      begin errors++; $display("FAIL inv_allones_done: done=%b ready=%b want 1 1", ap_done, ap_ready); end
    wr(A_OPCODE, OPC_INPUT);
    wait_state(4'd3, r);
    wr(A_OPCODE, OPC_ENDR);
    rd(A_STATUS, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL inv_endr_rdy: status %h want 3", r); end
    wr(A_OPCODE, OPC_NEXT);
    rd(A_STATUS, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL inv_next_rdy: status %h want 3", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    wr(A_OPCODE, OPC_RUN);
    rd(A_STATUS, r);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL mid_wait: status %h want 4", r); end
    ap_rst = 1'b0;
    #1;
    checks++; if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_return !== 32'd0)
      begin errors++; $display("FAIL mid_rst_out: idle=%b done=%b ret=%h want 1 0 0", ap_idle, ap_done, ap_return); end
    repeat (2) @(negedge clk);
    ap_rst = 1'b1;
    rd(A_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_status: got %h want 0", r); end
    rd(A_DUT_OUT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_dut_out: got %h want 0", r); end
    rd(A_DUT_IN, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_dut_in: got %h want 0", r); end
    run_one(32'h0000_0100);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_run_flow();
    test_scan();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/duft_ap_ctrl_hs.md
DUFT_AP_CTRL_HS -- requirements
Module: duft_ap_ctrl_hs

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports as below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 ap_rst  in  1  asynchronous active-low reset.
REQ-004 addr  in  32  register address of the host transaction.
REQ-005 wr_data  in  32  host write data.
REQ-006 rd_wr  in  1  1 = read, 0 = write.
REQ-007 ap_start  in  1  host request; sampled only while ap_idle=1.
REQ-008 ap_idle  out  1  high when able to accept a transaction.
REQ-009 ap_ready  out  1  one-cycle pulse, coincident with ap_done.
REQ-010 ap_done  out  1  one-cycle pulse; transaction complete.
REQ-011 ap_return  out  32  read data; held until the next transaction completes.

Function
REQ-012 SHALL run the handshake: ap_start=1 with ap_idle=1 at a clk edge latches addr/rd_wr/wr_data and drops ap_idle; the next edge raises ap_done/ap_ready for one cycle and applies the read or write; the following edge restores ap_idle.
REQ-013 SHALL use this address map: 0x0 OPCODE (W); 0x1 STATUS (R); 0x2 CONFIG (R/W scratch); 0x10 DUT_IN (R/W); 0x18 DUT_OUT (R); 0x20 DFT_OUT0 (R, scan snapshot); 0xFF000000 TEST_IN (W); 0xFF000001 TEST_OUT (R).
REQ-014 SHALL return 0 for reads of unmapped or write-only addresses and ignore writes to them; a transaction still completes.
REQ-015 SHALL decode opcodes NONE=0, INPUT=1, RUN=2, ENDR=3, TEST=4, NEXT=5, ENDT=6; other values SHALL act as NONE.
REQ-016 SHALL consume an opcode once: the OPCODE register clears to NONE in the cycle the FSM acts on it.
REQ-017 SHALL encode the controller FSM as IDLE=0, INPUT_FLATTEN=1, INPUT_DUT=2, INPUT_RDY=3, OUTPUT_WAIT=4, OUTPUT_VAL=5, OUTPUT_PACK=6, SCAN_PREP=7, SCAN=8, SCAN_RD=9, TICK=10.
REQ-018 Transitions: IDLE -INPUT-> INPUT_FLATTEN -> INPUT_DUT -> INPUT_RDY once the DUT accepts; INPUT_RDY -RUN-> OUTPUT_WAIT -> OUTPUT_VAL on DUT done; OUTPUT_VAL -ENDR-> OUTPUT_PACK, which latches DUT_OUT, -> IDLE.
REQ-019 Test path: INPUT_RDY -TEST-> SCAN_PREP -> SCAN (capture) -> SCAN_RD; SCAN_RD -NEXT-> TICK (exactly one DUT clock enable) -> SCAN -> SCAN_RD; SCAN_RD -ENDT-> IDLE.
REQ-020 Opcodes not valid in the current state SHALL be consumed and ignored.
REQ-021 STATUS[3:0]=FSM state; STATUS[11:4] = {dft_val_op, dft_op_ack, dft_op_commit, dft_commit_ack, dut_val_op, dut_op_ack, dut_op_commit, dut_commit_ack} (bit 11 first); STATUS[31:12]=0.
REQ-022 Embedded DUT: loads DUT_IN on accept, then adds 1 per enabled DUT clock; done, with dut_op_commit=1, after 8 enabled clocks, so the result is DUT_IN+8 modulo 2^32.
REQ-023 DUT clock enables SHALL occur every cycle in OUTPUT_WAIT and only in TICK on the test path.
REQ-024 SCAN SHALL copy the DUT accumulator to DFT_OUT0: the snapshot after the TEST capture is DUT_IN+0, and after the k-th NEXT it is DUT_IN+k.
REQ-025 dut_op_commit SHALL stay 1 from DUT completion until IDLE is re-entered.

Reset
REQ-026 ap_rst low SHALL asynchronously set: FSM=IDLE, all registers and flags=0, ap_idle=1, ap_done=0, ap_ready=0, ap_return=0.
REQ-027 Reset mid-transaction or mid-test SHALL abandon the operation with no partial output.

Configuration
REQ-028 With DUFT_TEST_REG_EN defined, a TEST_IN write SHALL be readable unchanged at TEST_OUT; without it, both addresses SHALL behave as unmapped.

Structure
REQ-029 SHALL place address constants, opcodes and state encodings in the shared package duft_pkg.
REQ-030 SHALL implement the iterative +1 DUT with its scan-capture port as the sub-module duft_dut.

Verification
REQ-031 With DUFT_TEST_REG_EN: write 0x7216 to TEST_IN -> TEST_OUT reads 0x7216.
REQ-032 DUT_IN=0x7216, then INPUT, RUN, ENDR -> STATUS[3:0] returns to 0 and DUT_OUT=0x721E; repeat with 0x0722 -> 0x072A.
REQ-033 DUT_IN=0x7216, then INPUT, TEST, then NEXT until dut_op_commit=1 in SCAN_RD -> DFT_OUT0 reads 0x7216..0x721E over 9 snapshots; ENDT -> IDLE.
REQ-034 100 random DUT_IN values through the run flow -> each DUT_OUT equals input+8, including 0xFFFFFFF8 -> 0x00000000.
REQ-035 Send RUN while IDLE -> state stays 0 and OPCODE reads as cleared; read 0xFFFFFFFF -> 0 with ap_done pulsed.
REQ-036 Assert ap_rst during OUTPUT_WAIT -> STATUS reads 0 and ap_idle=1.
